// File: rtl/mux_pkg.sv
`default_nettype none
// ===========================================================================
// mux_pkg : shared widths, legacy 5:1 select encodings, clamped-index helper
// Revision: 1.0
// ===========================================================================
package mux_pkg;

  localparam int DATA_W = 32;

  // Select encodings of the fixed 5-input data-path muxes being replaced
  localparam logic [2:0] SEL_PC    = 3'd0;
  localparam logic [2:0] SEL_ALU   = 3'd1;
  localparam logic [2:0] SEL_MEM   = 3'd2;
  localparam logic [2:0] SEL_SHIFT = 3'd3;
  localparam logic [2:0] SEL_IMM   = 3'd4;

  function automatic int unsigned clamp_idx(input int unsigned idx, input int unsigned n);
    return (idx >= n) ? (n - 1) : idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mux_nx1_comb.sv
`default_nettype none
// ===========================================================================
// mux_nx1_comb : combinational N:1 selector, out-of-range select -> input N-1
// Revision: 1.0
// ===========================================================================
module mux_nx1_comb
  import mux_pkg::*;
#(
  parameter int N  = 5,
  parameter int W  = DATA_W,
  parameter int SW = $clog2(N)
) (
  input  logic [N*W-1:0] data_in,
  input  logic [SW-1:0]  sel,
  output logic [W-1:0]   data_out,
  output logic           out_of_range
);

  logic [W-1:0]  words [N];
  logic [SW-1:0] sel_idx;

  for (genvar k = 0; k < N; k++) begin : g_unpack
    assign words[k] = data_in[k*W +: W];
  end

  // A power-of-two N leaves no select code outside the input range
  if ((1 << SW) == N) begin : g_pow2
    assign out_of_range = 1'b0;
  end else begin : g_npow2
    assign out_of_range = (32'(sel) >= 32'(N));
  end

  always_comb begin
    sel_idx  = SW'(clamp_idx(32'(sel), N));
    data_out = words[sel_idx];
  end

endmodule
`default_nettype wire

// File: rtl/mux_nx1_reg.sv
`default_nettype none
// ===========================================================================
// mux_nx1_reg : registered N:1 selector with valid/ready handshake and scan
// mode. Optional sticky sel_err port when MUX_NX1_SEL_ERR_EN is defined.
// Revision: 1.0
// ===========================================================================
module mux_nx1_reg
  import mux_pkg::*;
#(
  parameter int N  = 5,
  parameter int W  = DATA_W,
  parameter int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [N*W-1:0] data_in,
  input  logic [SW-1:0]  sel,
  input  logic           scan,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [W-1:0]   out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [SW-1:0]  scan_idx
`ifdef MUX_NX1_SEL_ERR_EN
  ,
  output logic           sel_err
`endif
);

  localparam logic [SW-1:0] SCAN_LAST = SW'(N - 1);

  logic [SW-1:0] eff_sel;
  logic [W-1:0]  sel_data;
  logic          sel_oor;
  logic          accept;

  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  out_data_q,  out_data_d;
  logic [SW-1:0] scan_q,      scan_d;

  assign eff_sel  = scan ? scan_q : sel;
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  mux_nx1_comb #(
    .N  (N),
    .W  (W),
    .SW (SW)
  ) u_sel (
    .data_in      (data_in),
    .sel          (eff_sel),
    .data_out     (sel_data),
    .out_of_range (sel_oor)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    scan_d      = scan_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
      if (scan) begin
        scan_d = (scan_q == SCAN_LAST) ? '0 : scan_q + 1'b1;
      end
    end else if (out_ready) begin
      // Drain only clears valid; the data word stays visible
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      scan_q      <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      scan_q      <= scan_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign scan_idx  = scan_q;

`ifdef MUX_NX1_SEL_ERR_EN
  logic sel_err_q, sel_err_d;

  // Only the external select can be out of range; the scan counter never is
  assign sel_err_d = sel_err_q | (accept && !scan && sel_oor);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= sel_err_d;
    end
  end

  assign sel_err = sel_err_q;
`else
  logic unused_sel_oor;
  assign unused_sel_oor = sel_oor;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mux_nx1_reg.sv
`default_nettype none
// ===========================================================================
// tb_mux_nx1_reg : scoreboard bench for mux_nx1_reg (N=5/W=32, N=2/W=8, N=16/W=32)
// Revision: 1.0
// ===========================================================================
module tb_mux_nx1_reg;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------- main DUT, N=5 W=32 ----------------
  logic [159:0] data_in;
  logic [2:0]   sel;
  logic         scan, in_valid, out_ready;
  logic         in_ready, out_valid;
  logic [31:0]  out_data;
  logic [2:0]   scan_idx;
  logic         sel_err;

  mux_nx1_reg #(.N(5), .W(32)) dut (
    .clk(clk), .reset_n(reset_n), .data_in(data_in), .sel(sel), .scan(scan),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .scan_idx(scan_idx)
`ifdef MUX_NX1_SEL_ERR_EN
    , .sel_err(sel_err)
`endif
  );
`ifndef MUX_NX1_SEL_ERR_EN
  assign sel_err = 1'b0;
`endif

  // ---------------- sweep DUTs ----------------
  logic [15:0]  d2_data;
  logic [0:0]   d2_sel, d2_idx;
  logic         d2_scan, d2_iv, d2_or, d2_ir, d2_ov, d2_err;
  logic [7:0]   d2_out;

  mux_nx1_reg #(.N(2), .W(8)) dut2 (
    .clk(clk), .reset_n(reset_n), .data_in(d2_data), .sel(d2_sel), .scan(d2_scan),
    .in_valid(d2_iv), .in_ready(d2_ir), .out_data(d2_out),
    .out_valid(d2_ov), .out_ready(d2_or), .scan_idx(d2_idx)
`ifdef MUX_NX1_SEL_ERR_EN
    , .sel_err(d2_err)
`endif
  );

  logic [511:0] d16_data;
  logic [3:0]   d16_sel, d16_idx;
  logic         d16_scan, d16_iv, d16_or, d16_ir, d16_ov, d16_err;
  logic [31:0]  d16_out;

  mux_nx1_reg #(.N(16), .W(32)) dut16 (
    .clk(clk), .reset_n(reset_n), .data_in(d16_data), .sel(d16_sel), .scan(d16_scan),
    .in_valid(d16_iv), .in_ready(d16_ir), .out_data(d16_out),
    .out_valid(d16_ov), .out_ready(d16_or), .scan_idx(d16_idx)
`ifdef MUX_NX1_SEL_ERR_EN
    , .sel_err(d16_err)
`endif
  );
`ifndef MUX_NX1_SEL_ERR_EN
  assign d2_err  = 1'b0;
  assign d16_err = 1'b0;
`endif

  // ---------------- reference models ----------------
  logic [31:0] q5[$];
  logic [7:0]  q2[$];
  logic [31:0] q16[$];
  bit          m_valid, m_err;
  logic [31:0] m_data;
  int          m_scan;
  bit          m2_valid, m16_valid;
  int          m2_scan, m16_scan;
  int          n_push, n_pop;

  task automatic model_reset();
    m_valid = 0; m_err = 0; m_data = '0; m_scan = 0; q5.delete();
    m2_valid = 0; m2_scan = 0; q2.delete();
    m16_valid = 0; m16_scan = 0; q16.delete();
  endtask

  task automatic load_legacy();
    for (int k = 0; k < 5; k++) data_in[k*32 +: 32] = 32'h10 + 32'(k);
  endtask

  // One clock of the N=5 DUT against the scoreboard model
  task automatic step();
    int eff, idx;
    logic [31:0] exp;
    bit rdy, acc;
    @(negedge clk);
    rdy = !m_valid || out_ready;
    total++; if (in_ready !== rdy) begin bad++; $display("FAIL in_ready: got %b want %b", in_ready, rdy); end
    total++; if (out_valid !== m_valid) begin bad++; $display("FAIL out_valid: got %b want %b", out_valid, m_valid); end
    total++; if (out_data !== m_data) begin bad++; $display("FAIL out_data_hold: got %h want %h", out_data, m_data); end
    if (m_valid && out_ready) begin
      total++;
      if (q5.size() == 0) begin bad++; $display("FAIL sb5_empty: got output %h want none", out_data); end
      else begin
        exp = q5.pop_front();
        if (out_data !== exp) begin bad++; $display("FAIL sb5_data: got %h want %h", out_data, exp); end
      end
    end
    acc = in_valid && rdy;
    if (acc) begin
      eff = scan ? m_scan : int'(sel);
      idx = (eff >= 5) ? 4 : eff;
      exp = data_in[idx*32 +: 32];
      q5.push_back(exp);
      m_data = exp;
      if (scan) m_scan = (m_scan == 4) ? 0 : m_scan + 1;
      else if (int'(sel) >= 5) m_err = 1'b1;
      m_valid = 1'b1;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    @(posedge clk); #1;
    total++; if (scan_idx !== 3'(m_scan)) begin bad++; $display("FAIL scan_idx: got %0d want %0d", scan_idx, m_scan); end
`ifdef MUX_NX1_SEL_ERR_EN
    total++; if (sel_err !== m_err) begin bad++; $display("FAIL sel_err: got %b want %b", sel_err, m_err); end
`endif
  endtask

  // One clock of both sweep DUTs against their models
  task automatic step_sw();
    int eff;
    logic [7:0] e2;
    logic [31:0] e16;
    bit rdy, acc;
    @(negedge clk);
    rdy = !m2_valid || d2_or;
    total++; if (d2_ir !== rdy || d2_ov !== m2_valid) begin bad++; $display("FAIL n2_hs: got ir=%b ov=%b want ir=%b ov=%b", d2_ir, d2_ov, rdy, m2_valid); end
    if (m2_valid && d2_or) begin
      total++;
      if (q2.size() == 0) begin bad++; $display("FAIL sb2_empty: got output %h want none", d2_out); end
      else begin
        e2 = q2.pop_front(); n_pop++;
        if (d2_out !== e2) begin bad++; $display("FAIL sb2_data: got %h want %h", d2_out, e2); end
      end
    end
    acc = d2_iv && rdy;
    if (acc) begin
      eff = d2_scan ? m2_scan : int'(d2_sel);
      if (eff >= 2) eff = 1;
      q2.push_back(d2_data[eff*8 +: 8]); n_push++;
      if (d2_scan) m2_scan = (m2_scan == 1) ? 0 : m2_scan + 1;
      m2_valid = 1'b1;
    end else if (d2_or) m2_valid = 1'b0;

    rdy = !m16_valid || d16_or;
    total++; if (d16_ir !== rdy || d16_ov !== m16_valid) begin bad++; $display("FAIL n16_hs: got ir=%b ov=%b want ir=%b ov=%b", d16_ir, d16_ov, rdy, m16_valid); end
    if (m16_valid && d16_or) begin
      total++;
      if (q16.size() == 0) begin bad++; $display("FAIL sb16_empty: got output %h want none", d16_out); end
      else begin
        e16 = q16.pop_front(); n_pop++;
        if (d16_out !== e16) begin bad++; $display("FAIL sb16_data: got %h want %h", d16_out, e16); end
      end
    end
    acc = d16_iv && rdy;
    if (acc) begin
      eff = d16_scan ? m16_scan : int'(d16_sel);
      if (eff >= 16) eff = 15;
      q16.push_back(d16_data[eff*32 +: 32]); n_push++;
      if (d16_scan) m16_scan = (m16_scan == 15) ? 0 : m16_scan + 1;
      m16_valid = 1'b1;
    end else if (d16_or) m16_valid = 1'b0;

    @(posedge clk); #1;
    total++; if (d2_idx !== 1'(m2_scan) || d16_idx !== 4'(m16_scan)) begin bad++; $display("FAIL sweep_scan_idx: got %0d/%0d want %0d/%0d", d2_idx, d16_idx, m2_scan, m16_scan); end
    total++; if (d2_err !== 1'b0 || d16_err !== 1'b0) begin bad++; $display("FAIL pow2_sel_err: got %b/%b want 0/0", d2_err, d16_err); end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    data_in = '0; sel = '0; scan = 0; in_valid = 0; out_ready = 1;
    d2_data = '0; d2_sel = '0; d2_scan = 0; d2_iv = 0; d2_or = 1;
    d16_data = '0; d16_sel = '0; d16_scan = 0; d16_iv = 0; d16_or = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0 || out_data !== 32'h0) begin bad++; $display("FAIL reset_out: got v=%b d=%h want v=0 d=0", out_valid, out_data); end
    total++; if (scan_idx !== 3'd0 || in_ready !== 1'b1) begin bad++; $display("FAIL reset_idx_rdy: got idx=%0d rdy=%b want 0/1", scan_idx, in_ready); end
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    load_legacy();
    sel = 3'd3; in_valid = 1; out_ready = 1;
    step();
    total++; if (out_valid !== 1'b1 || out_data !== 32'h13) begin bad++; $display("FAIL basic_capture: got v=%b d=%h want v=1 d=13", out_valid, out_data); end
    in_valid = 0;
    step();
    total++; if (out_valid !== 1'b0 || out_data !== 32'h13) begin bad++; $display("FAIL basic_drain: got v=%b d=%h want v=0 d=13", out_valid, out_data); end
  endtask

  task automatic test_stall();
    sel = 3'd1; in_valid = 1; out_ready = 1;
    step();
    out_ready = 0; sel = 3'd4;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (in_ready !== 1'b0 || out_data !== 32'h11 || out_valid !== 1'b1) begin bad++; $display("FAIL stall_hold: got rdy=%b v=%b d=%h want rdy=0 v=1 d=11", in_ready, out_valid, out_data); end
    end
    out_ready = 1;
    step();
    total++; if (out_valid !== 1'b1 || out_data !== 32'h14) begin bad++; $display("FAIL stall_release: got v=%b d=%h want v=1 d=14", out_valid, out_data); end
    in_valid = 0;
    step();
  endtask

  task automatic test_scan_wrap();
    logic [31:0] seq [7];
    seq = '{32'h10, 32'h11, 32'h12, 32'h13, 32'h14, 32'h10, 32'h11};
    scan = 1; in_valid = 1; out_ready = 1; sel = 3'd0;
    for (int i = 0; i < 7; i++) begin
      step();
      total++; if (out_data !== seq[i]) begin bad++; $display("FAIL scan_seq[%0d]: got %h want %h", i, out_data, seq[i]); end
    end
    total++; if (scan_idx !== 3'd2) begin bad++; $display("FAIL scan_end: got %0d want 2", scan_idx); end
    scan = 0; in_valid = 0;
    step();
  endtask

  task automatic test_out_of_range();
    sel = 3'd6; in_valid = 1; out_ready = 1;
    step();
    total++; if (out_data !== 32'h14) begin bad++; $display("FAIL oor_clamp: got %h want 14", out_data); end
`ifdef MUX_NX1_SEL_ERR_EN
    total++; if (sel_err !== 1'b1) begin bad++; $display("FAIL oor_err_set: got %b want 1", sel_err); end
`endif
    sel = 3'd0;
    step();
    total++; if (out_data !== 32'h10) begin bad++; $display("FAIL oor_next: got %h want 10", out_data); end
`ifdef MUX_NX1_SEL_ERR_EN
    total++; if (sel_err !== 1'b1) begin bad++; $display("FAIL oor_err_sticky: got %b want 1", sel_err); end
`endif
    in_valid = 0;
    step();
  endtask

  task automatic test_async_reset();
    sel = 3'd2; in_valid = 1; out_ready = 1;
    step();
    out_ready = 0; in_valid = 0;
    step();
    total++; if (out_valid !== 1'b1 || scan_idx !== 3'd2) begin bad++; $display("FAIL pre_reset: got v=%b idx=%0d want v=1 idx=2", out_valid, scan_idx); end
    #2 reset_n = 1'b0;
    #2;
    total++; if (out_valid !== 1'b0 || out_data !== 32'h0 || scan_idx !== 3'd0) begin bad++; $display("FAIL async_reset: got v=%b d=%h idx=%0d want 0/0/0", out_valid, out_data, scan_idx); end
`ifdef MUX_NX1_SEL_ERR_EN
    total++; if (sel_err !== 1'b0) begin bad++; $display("FAIL async_reset_err: got %b want 0", sel_err); end
`endif
    #1 reset_n = 1'b1;
    model_reset();
    out_ready = 1;
    step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      for (int k = 0; k < 5; k++) data_in[k*32 +: 32] = $urandom;
      sel = 3'($urandom_range(0, 7));
      scan = ($urandom_range(0, 3) == 0);
      in_valid = $urandom_range(0, 1) == 1;
      out_ready = $urandom_range(0, 2) != 0;
      step();
    end
    in_valid = 0; out_ready = 1; scan = 0;
    repeat (2) step();
    total++; if (q5.size() != 0) begin bad++; $display("FAIL sb5_leftover: got %0d want 0", q5.size()); end
  endtask

  task automatic test_sweep();
    n_push = 0; n_pop = 0;
    for (int i = 0; i < 200; i++) begin
      d2_data = 16'($urandom);
      for (int k = 0; k < 16; k++) d16_data[k*32 +: 32] = $urandom;
      d2_sel = 1'($urandom_range(0, 1));
      d16_sel = 4'($urandom_range(0, 15));
      d2_scan = ($urandom_range(0, 3) == 0);
      d16_scan = ($urandom_range(0, 3) == 0);
      d2_iv = $urandom_range(0, 1) == 1;
      d16_iv = $urandom_range(0, 3) != 0;
      d2_or = $urandom_range(0, 2) != 0;
      d16_or = $urandom_range(0, 1) == 1;
      step_sw();
    end
    d2_iv = 0; d16_iv = 0; d2_or = 1; d16_or = 1;
    repeat (2) step_sw();
    total++; if (n_push != n_pop || q2.size() != 0 || q16.size() != 0) begin bad++; $display("FAIL sweep_count: got pushed=%0d popped=%0d want equal", n_push, n_pop); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_scan_wrap();
    test_out_of_range();
    test_async_reset();
    test_random();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mux_nx1_reg.md
Name: mux_nx1_reg

Overview:
- Parametrised N-input, W-bit selector with a registered output stage and a valid/ready handshake.
- Successor to the fixed 5-input combinational data-path muxes.
- Sits between data-path sources (PC, ALU, memory data, shifted values) and destination registers of the multicycle CPU, so the selected value can be held across stalls.
- Adds an internal scan mode: the select auto-increments per accepted transfer, which serialises several sources through one port.

Parameters:
- N, 5, number of data inputs (2..16).
- W, 32, data width in bits.
- SW, $clog2(N), select width (derived; do not override).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous reset, active-low.
- data_in  in  N*W  flattened inputs; input k occupies bits [k*W +: W].
- sel  in  SW  external select, used when scan=0.
- scan  in  1  1 = use internal scan counter as select.
- in_valid  in  1  request to capture a selection this cycle.
- in_ready  out  1  stage can accept.
- out_data  out  W  registered selected data.
- out_valid  out  1  out_data holds an unconsumed value.
- out_ready  in  1  consumer accepts out_data.
- scan_idx  out  SW  current scan-counter value.

Behaviour:
- Reset (reset_n=0, asynchronous): out_data=0, out_valid=0, scan counter=0, sel_err=0 (when present).
- in_ready = !out_valid || out_ready. Combinational; one-deep stage, full throughput.
- Accept: in_valid && in_ready at a rising edge. On accept:
  - out_data <= data_in[eff_sel]
  - out_valid <= 1
- Effective select: eff_sel = scan ? scan_counter : sel.
- Out-of-range select (eff_sel >= N): selects input N-1. This keeps the highest-input priority of the legacy muxes.
- Drain without accept: out_valid && out_ready && !accept clears out_valid. out_data holds its last value, never cleared.
- Simultaneous drain and accept: out_valid stays 1 and out_data takes the new value (back-to-back, no bubble).
- Stall: out_valid && !out_ready. out_data and out_valid hold; in_ready=0; data_in and sel are ignored.
- Scan counter:
  - Advances only on an accept with scan=1.
  - Sequence 0,1,…,N-1, then wraps to 0.
  - Holds when scan=0 or when there is no accept.
- Toggling scan does not reset the counter.
- Latency: 1 cycle from accept to out_valid.
- Reset mid-transfer discards the held value immediately, without waiting for a clock edge.
- Non-power-of-two N: counter values >= N are unreachable. Only sel can be out of range.

Optional Feature:
- Macro: MUX_NX1_SEL_ERR_EN.
- Defined: adds output port sel_err (1 bit), a sticky flag.
  - Set on any accept with scan=0 and sel >= N.
  - Cleared only by reset.
  - The fallback to input N-1 still applies.
- Undefined: no sel_err port; out-of-range selects are silently mapped to input N-1.
- With N a power of two, sel_err is tied to 0.

Decomposition:
- Shared package/header `mux_pkg`: default widths (DATA_W=32), legacy mux select encodings as localparams, and a helper function for the clamped select index.
- One sub-module: `mux_nx1_comb`, the purely combinational parametrised N:1 selector with clamping. It is reusable to replace the fixed-size muxes.
- mux_nx1_reg instantiates mux_nx1_comb and adds the handshake register and scan counter.

Test Plan:
1. Reset and basic capture (N=5, W=32):
   - Stimulus: inputs 0x10,0x11,0x12,0x13,0x14; deassert reset; sel=3, in_valid=1 for one cycle, out_ready=1.
   - Required: before the edge, out_data=0 and out_valid=0. Next cycle, out_data=0x13 and out_valid=1. Following cycle, out_valid=0 and out_data still 0x13.
2. Stall/backpressure:
   - Stimulus: capture sel=1; out_ready=0 for 3 cycles while sel changes to 4 and in_valid=1.
   - Required: in_ready=0 and out_data=0x11 held. When out_ready=1, the same-cycle accept gives out_data=0x14 with out_valid staying 1.
3. Scan wrap:
   - Stimulus: scan=1, in_valid=1, out_ready=1 for 7 cycles.
   - Required: out_data sequence 0x10,0x11,0x12,0x13,0x14,0x10,0x11; scan_idx ends at 2.
4. Out-of-range select:
   - Stimulus: sel=6 (SW=3), accept.
   - Required: out_data=0x14.
   - With MUX_NX1_SEL_ERR_EN: sel_err=1 and it stays 1 after a later sel=0 accept.
5. Async reset mid-stall:
   - Stimulus: out_valid=1, out_ready=0; pulse reset_n low between clock edges.
   - Required: out_valid=0, out_data=0 and scan_idx=0 immediately, without waiting for a clock edge.
6. Parameter sweep:
   - Stimulus: N=2/W=8 and N=16/W=32; random sel/valid/ready against a reference queue model.
   - Required: no lost or duplicated transfers, and every output equals data_in[clamped eff_sel] at its accept.
